fr_cmd_sequencer: RTL and testbench
===================================

FR_CMD_SEQUENCER -- requirements
Module: fr_cmd_sequencer

Interface
REQ-001 SHALL have parameter NB_C0M, default 8, command field width.
REQ-002 SHALL have parameter NB_INST, default 32, GPIO instruction word width.
REQ-003 SHALL have parameter NB_BER, default 64, response width.
REQ-004 SHALL have parameter STROBE_CYC, default 2, cycles the strobe bit is held high (legal 1..15).
REQ-005 SHALL have parameter RESP_WAIT, default 4, settle cycles after strobe falls before GPI is sampled (legal 1..15).
REQ-006 SHALL have port clock, input, 1, system clock; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port i_reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_req_valid, input, 1, host request valid.
REQ-009 SHALL have port o_req_ready, output, 1, sequencer idle, can accept a request.
REQ-010 SHALL have port i_req_cmd, input, NB_C0M, command code.
REQ-011 SHALL have port i_req_data, input, 23, command payload.
REQ-012 SHALL have port o_gpo, output, NB_INST, instruction word to file register: [31:24] cmd, [23] strobe, [22:0] payload.
REQ-013 SHALL have port i_gpi, input, NB_INST, response word from file register.
REQ-014 SHALL have port o_resp_valid, output, 1, one-cycle response pulse.
REQ-015 SHALL have port o_resp_data, output, NB_BER, captured response.
REQ-016 SHALL have port o_busy, output, 1, high in every non-IDLE state.

Function
REQ-017 SHALL use FSM states IDLE, STROBE, WAIT, HI_STROBE, HI_WAIT; o_req_ready = (state==IDLE).
REQ-018 SHALL accept a request on the edge where i_req_valid && o_req_ready; cmd/payload registered; i_req_* ignored while busy (no queueing).
REQ-019 SHALL drive o_gpo = {cmd,1,payload} for exactly STROBE_CYC cycles after acceptance (STROBE), then {cmd,0,payload} for RESP_WAIT cycles (WAIT).
REQ-020 SHALL sample i_gpi on the last WAIT cycle into o_resp_data[31:0], zero [63:32], pulse o_resp_valid for one cycle in the cycle after, and return to IDLE in that same cycle.
REQ-021 SHALL have latency from acceptance edge to o_resp_valid of STROBE_CYC+RESP_WAIT+1 cycles (7 with defaults).
REQ-022 SHALL allow a new request accepted in the o_resp_valid cycle (back-to-back, no idle gap).
REQ-023 SHALL hold o_gpo with strobe=0 and last cmd/payload while IDLE; o_resp_data holds until next capture.
REQ-024 SHALL use a 4-bit down-counter for STROBE/WAIT dwell; reloaded on every state entry; no wrap beyond zero.
REQ-025 SHALL pass all command codes unmodified, including 0x00 and undefined codes (no decode except REQ-031).
REQ-026 SHALL have no response backpressure; o_resp_valid never asserts twice per request.

Reset
REQ-027 SHALL, on i_reset low, asynchronously force state IDLE, counter 0, o_gpo 0, o_resp_data 0, o_resp_valid 0, o_busy 0; o_req_ready 1.
REQ-028 SHALL abort any operation in progress when reset is asserted mid-operation; no o_resp_valid for the aborted request.
REQ-029 SHALL leave reset synchronously to clock (first acceptance no earlier than first rising edge with i_reset high).

Configuration
REQ-030 SHALL compile the wide BER read path only when macro FR_SEQ_BER_WIDE_READ_EN is defined.
REQ-031 SHALL, with FR_SEQ_BER_WIDE_READ_EN, for cmd 0x08..0x0B, after low capture enter HI_STROBE/HI_WAIT driving {0x0C,strobe,0} with identical timing, capture i_gpi into [63:32], then pulse o_resp_valid; latency 2*(STROBE_CYC+RESP_WAIT)+1 (13 default).
REQ-032 SHALL, without the macro, treat 0x08..0x0B as ordinary single reads (upper 32 bits zero); HI_* states not present.

Verification
REQ-033 SHALL cover: reset release, request cmd 0x02 payload 1 -> o_gpo 0x02800001 cycles 1-2, 0x02000001 cycles 3-6, o_resp_valid at cycle 7.
REQ-034 SHALL cover: cmd 0x07, i_gpi=0x00000001 during WAIT -> o_resp_data 0x0000000000000001, one pulse.
REQ-035 SHALL cover: macro defined, cmd 0x0A, i_gpi 0x12345678 then 0x9ABCDEF0 after 0x0C issued -> o_resp_data 0x9ABCDEF012345678 at cycle 13.
REQ-036 SHALL cover: i_req_valid held high continuously -> acceptances at cycles 0, 7, 14; i_req changes while busy ignored.
REQ-037 SHALL cover: i_reset low at cycle 3 of a request -> o_gpo 0 immediately, no o_resp_valid, o_req_ready 1 after release.

Source files
------------

// File: rtl/fr_cmd_sequencer.sv
// fr_cmd_sequencer: drives a command word to a file register, holds the strobe
// bit high for STROBE_CYC cycles, waits RESP_WAIT cycles, samples the response
// word and reports it with a one-cycle valid pulse.
// Optional feature: define FR_SEQ_BER_WIDE_READ_EN to enable the two-phase
// 64-bit BER read for commands 0x08..0x0B (second phase issues command 0x0C).
module fr_cmd_sequencer #(
  parameter int NB_C0M     = 8,
  parameter int NB_INST    = 32,
  parameter int NB_BER     = 64,
  parameter int STROBE_CYC = 2,
  parameter int RESP_WAIT  = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [NB_C0M-1:0]  i_req_cmd,
  input  logic [22:0]        i_req_data,
  output logic [NB_INST-1:0] o_gpo,
  input  logic [NB_INST-1:0] i_gpi,
  output logic               o_resp_valid,
  output logic [NB_BER-1:0]  o_resp_data,
  output logic               o_busy
);

  // Dwell counters count down to zero, so the reload value is one less than
  // the number of cycles spent in the state.
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] WAIT_LOAD   = 4'(RESP_WAIT - 1);

`ifdef FR_SEQ_BER_WIDE_READ_EN
  localparam logic [NB_C0M-1:0] HI_CMD = NB_C0M'(12);
  typedef enum logic [2:0] {IDLE, STROBE, WAIT, HI_STROBE, HI_WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, STROBE, WAIT} state_t;
`endif

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [NB_C0M-1:0]   cmd_q, cmd_d;
  logic [22:0]         data_q, data_d;
  logic [NB_INST-1:0]  gpo_q, gpo_d;
  logic [NB_BER-1:0]   resp_q, resp_d;
  logic                valid_q, valid_d;

`ifdef FR_SEQ_BER_WIDE_READ_EN
  logic is_wide;
  assign is_wide = (cmd_q >= NB_C0M'(8)) && (cmd_q <= NB_C0M'(11));
`endif

  // State, dwell counter and all registered outputs; async active-low reset.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      gpo_q   <= '0;
      resp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      gpo_q   <= gpo_d;
      resp_q  <= resp_d;
      valid_q <= valid_d;
    end
  end

  // Next-state, counter reload/decrement and output-register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 4'd1 : '0;
    cmd_d   = cmd_q;
    data_d  = data_q;
    gpo_d   = gpo_q;
    resp_d  = resp_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          cmd_d   = i_req_cmd;
          data_d  = i_req_data;
          gpo_d   = NB_INST'({i_req_cmd, 1'b1, i_req_data});
          cnt_d   = STROBE_LOAD;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          gpo_d   = NB_INST'({cmd_q, 1'b0, data_q});
          cnt_d   = WAIT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          resp_d = NB_BER'(i_gpi);
`ifdef FR_SEQ_BER_WIDE_READ_EN
          if (is_wide) begin
            gpo_d   = NB_INST'({HI_CMD, 1'b1, 23'd0});
            cnt_d   = STROBE_LOAD;
            state_d = HI_STROBE;
          end else begin
            valid_d = 1'b1;
            state_d = IDLE;
          end
`else
          valid_d = 1'b1;
          state_d = IDLE;
`endif
        end
      end
`ifdef FR_SEQ_BER_WIDE_READ_EN
      HI_STROBE: begin
        if (cnt_q == '0) begin
          gpo_d   = NB_INST'({HI_CMD, 1'b0, 23'd0});
          cnt_d   = WAIT_LOAD;
          state_d = HI_WAIT;
        end
      end
      HI_WAIT: begin
        if (cnt_q == '0) begin
          resp_d  = NB_BER'({i_gpi, resp_q[NB_INST-1:0]});
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign o_req_ready  = (state_q == IDLE);
  assign o_busy       = (state_q != IDLE);
  assign o_gpo        = gpo_q;
  assign o_resp_data  = resp_q;
  assign o_resp_valid = valid_q;

endmodule

// File: tb/tb_fr_cmd_sequencer.sv
// Self-checking bench for fr_cmd_sequencer: table of single requests with
// per-cycle o_gpo checks, response scoreboard, back-to-back and reset-abort
// sequences. Honours FR_SEQ_BER_WIDE_READ_EN for the wide-read expectations.
module tb_fr_cmd_sequencer;

  localparam int S = 2;
  localparam int W = 4;

  logic        clock = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [7:0]  i_req_cmd;
  logic [22:0] i_req_data;
  logic [31:0] o_gpo;
  logic [31:0] i_gpi;
  logic        o_resp_valid;
  logic [63:0] o_resp_data;
  logic        o_busy;

  fr_cmd_sequencer #(
    .NB_C0M(8), .NB_INST(32), .NB_BER(64), .STROBE_CYC(S), .RESP_WAIT(W)
  ) dut (
    .clock(clock), .i_reset(i_reset), .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready), .i_req_cmd(i_req_cmd), .i_req_data(i_req_data),
    .o_gpo(o_gpo), .i_gpi(i_gpi), .o_resp_valid(o_resp_valid),
    .o_resp_data(o_resp_data), .o_busy(o_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [22:0] data;
    logic [31:0] gpi_lo;
    logic [31:0] gpi_hi;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] exp;
    int          acc_edge;
    int          lat;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic wide_cmd(input logic [7:0] c);
`ifdef FR_SEQ_BER_WIDE_READ_EN
    return (c >= 8'h08) && (c <= 8'h0B);
`else
    return 1'b0;
`endif
  endfunction

  // Expected o_gpo during cycle i (1-based) after the acceptance edge.
  function automatic logic [31:0] gpo_model(input logic [7:0] c, input logic [22:0] d,
                                            input int i, input logic wide);
    if (i <= S)                return {c, 1'b1, d};
    if (i <= S + W || !wide)   return {c, 1'b0, d};
    if (i <= 2 * S + W)        return {8'h0C, 1'b1, 23'd0};
    return {8'h0C, 1'b0, 23'd0};
  endfunction

  // Response monitor: every valid pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    if (i_reset && o_resp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp_valid: got data %h with nothing outstanding", o_resp_data);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("resp_data", o_resp_data, e.exp);
        check("resp_latency", 64'(cyc - e.acc_edge + 1), 64'(e.lat));
      end
    end
  end

  task automatic run_req(input vec_t v);
    int   n;
    int   lat;
    logic wide;
    wide = wide_cmd(v.cmd);
    lat  = wide ? 2 * (S + W) + 1 : S + W + 1;
    i_req_valid = 1'b1;
    i_req_cmd   = v.cmd;
    i_req_data  = v.data;
    i_gpi       = v.gpi_lo;
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!o_req_ready) begin
      check("ready_timeout", 64'(o_req_ready), 64'd1);
      i_req_valid = 1'b0;
      return;
    end
    sb_q.push_back('{v.exp, cyc + 1, lat});
    for (int i = 1; i <= lat; i++) begin
      @(negedge clock);
      if (i < lat) begin
        i_req_valid = 1'b1;
        i_req_cmd   = ~v.cmd;
        i_req_data  = 23'($urandom);
      end else begin
        i_req_valid = 1'b0;
      end
      i_gpi = (i >= S + W + 1) ? v.gpi_hi : v.gpi_lo;
      check("gpo", 64'(o_gpo), 64'(gpo_model(v.cmd, v.data, i, wide)));
      check("busy", 64'(o_busy), 64'(i < lat));
    end
    @(negedge clock);
    i_gpi = $urandom;
    check("resp_hold", o_resp_data, v.exp);
    check("gpo_idle_hold", 64'(o_gpo), 64'(gpo_model(v.cmd, v.data, lat, wide)));
    check("ready_idle", 64'(o_req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc[3];
    int na;
    int n;

    vecs[0] = '{8'h02, 23'h000001, 32'hCAFEF00D, 32'h0, 64'h00000000CAFEF00D};
    vecs[1] = '{8'h07, 23'h7FFFFF, 32'h00000001, 32'h0, 64'h0000000000000001};
    vecs[2] = '{8'h00, 23'h000000, 32'hFFFFFFFF, 32'h0, 64'h00000000FFFFFFFF};
    vecs[3] = '{8'hFF, 23'h555555, 32'hA5A5A5A5, 32'h0, 64'h00000000A5A5A5A5};
`ifdef FR_SEQ_BER_WIDE_READ_EN
    vecs[4] = '{8'h0A, 23'h000123, 32'h12345678, 32'h9ABCDEF0, 64'h9ABCDEF012345678};
    vecs[5] = '{8'h08, 23'h400000, 32'h00000001, 32'h00000002, 64'h0000000200000001};
    vecs[6] = '{8'h0B, 23'h2AAAAA, 32'h0BADF00D, 32'hFEEDBEEF, 64'hFEEDBEEF0BADF00D};
`else
    vecs[4] = '{8'h0A, 23'h000123, 32'h12345678, 32'h9ABCDEF0, 64'h0000000012345678};
    vecs[5] = '{8'h08, 23'h400000, 32'h00000001, 32'h00000002, 64'h0000000000000001};
    vecs[6] = '{8'h0B, 23'h2AAAAA, 32'h0BADF00D, 32'hFEEDBEEF, 64'h000000000BADF00D};
`endif
    vecs[7] = '{8'h0C, 23'h0000AB, 32'h0000DEAD, 32'h11111111, 64'h000000000000DEAD};

    i_reset     = 1'b0;
    i_req_valid = 1'b0;
    i_req_cmd   = '0;
    i_req_data  = '0;
    i_gpi       = '0;
    @(negedge clock);
    @(negedge clock);
    check("rst_gpo", 64'(o_gpo), 64'd0);
    check("rst_ready", 64'(o_req_ready), 64'd1);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_valid", 64'(o_resp_valid), 64'd0);
    check("rst_resp", o_resp_data, 64'd0);
    i_reset = 1'b1;
    @(negedge clock);

    for (int k = 0; k < 8; k++) run_req(vecs[k]);

    // Back-to-back: valid held high, request fields change every cycle.
    i_gpi = 32'h13579BDF;
    na = 0;
    n = 0;
    i_req_valid = 1'b1;
    while (na < 3 && n < 40) begin
      i_req_cmd  = 8'h10 + 8'(n);
      i_req_data = 23'(n);
      if (o_req_ready) begin
        acc[na] = cyc + 1;
        sb_q.push_back('{64'h0000000013579BDF, cyc + 1, S + W + 1});
        na++;
      end
      @(negedge clock);
      n++;
    end
    i_req_valid = 1'b0;
    check("b2b_accept_count", 64'(na), 64'd3);
    if (na == 3) begin
      check("b2b_second_accept", 64'(acc[1] - acc[0]), 64'(S + W + 1));
      check("b2b_third_accept", 64'(acc[2] - acc[0]), 64'(2 * (S + W + 1)));
    end
    n = 0;
    while (sb_q.size() != 0 && n < 30) begin
      @(negedge clock);
      n++;
    end
    check("b2b_drained", 64'(sb_q.size()), 64'd0);
    @(negedge clock);

    // Reset during the third cycle of a request aborts it.
    i_req_valid = 1'b1;
    i_req_cmd   = 8'h05;
    i_req_data  = 23'h000011;
    i_gpi       = 32'h00000077;
    check("abort_ready", 64'(o_req_ready), 64'd1);
    sb_q.push_back('{64'h0000000000000077, cyc + 1, S + W + 1});
    @(negedge clock);
    i_req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("abort_gpo_pre", 64'(o_gpo), 64'h0000000005000011);
    #2 i_reset = 1'b0;
    sb_q.delete();
    #1;
    check("abort_gpo", 64'(o_gpo), 64'd0);
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_ready_rst", 64'(o_req_ready), 64'd1);
    check("abort_resp", o_resp_data, 64'd0);
    repeat (3) @(negedge clock);
    i_reset = 1'b1;
    repeat (12) @(negedge clock);
    check("abort_ready_after", 64'(o_req_ready), 64'd1);
    check("abort_no_resp", o_resp_data, 64'd0);

    run_req(vecs[0]);
    repeat (3) @(negedge clock);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
